// File: rtl/rename_table_pkg.sv
// ============================================================================
// Package     : rename_table_pkg
// Description : Shared widths, the "no tag" encoding and the checkpoint record
//               for the register alias table and its free-tag pool.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rename_table_pkg;

   localparam int ARCH_REG_W = 5;
   localparam int TAG_W      = 6;
   localparam int NUM_ARCH   = 32;
   localparam int PTR_W      = TAG_W + 1;

   localparam logic [TAG_W-1:0] TAG_NONE = 6'h00;

   typedef logic [NUM_ARCH-1:0][TAG_W-1:0] map_t;

   // Branch checkpoint: the alias map plus the free-list head it pairs with
   typedef struct packed {
      map_t             map;
      logic [PTR_W-1:0] head;
   } rename_ckpt_t;

   // Architectural x0 is hard-wired, so it never has a producer tag
   function automatic logic [TAG_W-1:0] map_lookup(input map_t m,
                                                   input logic [ARCH_REG_W-1:0] r);
      return (r == '0) ? TAG_NONE : m[r];
   endfunction

endpackage

`default_nettype wire

// File: rtl/rename_free_list.sv
// ============================================================================
// Module      : rename_free_list
// Description : Circular FIFO of free rename tags, two pops and two pushes per
//               cycle. Pointers carry one extra bit so count = tail - head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_free_list
   import rename_table_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [1:0]                  pop_count_i,
   input  logic [1:0]                  push_valid_i,
   input  logic [1:0][TAG_W-1:0]       push_tag_i,
   input  logic                        restore_i,
   input  logic [PTR_W-1:0]            restore_head_i,
   output logic [1:0][TAG_W-1:0]       head_tag_o,
   output logic [PTR_W-1:0]            head_o,
   output logic [PTR_W-1:0]            count_o,
   output logic                        overflow_o
);

   localparam int               IDX_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] CAP   = PTR_W'(DEPTH - 1);

   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] head_p1;
   logic [PTR_W-1:0] tail_p1;
   logic             push0_ok, push1_ok;

   // Head tags, push acceptance against capacity, and next pointers
   always_comb begin
      count_o       = tail_q - head_q;
      head_o        = head_q;
      head_p1       = head_q + PTR_W'(1);
      head_tag_o[0] = (count_o != '0)        ? mem_q[head_q[IDX_W-1:0]]  : TAG_NONE;
      head_tag_o[1] = (count_o > PTR_W'(1))  ? mem_q[head_p1[IDX_W-1:0]] : TAG_NONE;
      // Capacity is judged on the pre-pop occupancy; port 0 lands first
      push0_ok      = push_valid_i[0] && (count_o < CAP);
      push1_ok      = push_valid_i[1] && ((count_o + PTR_W'(push0_ok)) < CAP);
      overflow_o    = (push_valid_i[0] && !push0_ok) || (push_valid_i[1] && !push1_ok);
      tail_p1       = tail_q + PTR_W'(push0_ok);
      tail_d        = tail_p1 + PTR_W'(push1_ok);
      head_d        = restore_i ? restore_head_i : head_q + PTR_W'(pop_count_i);
   end

   // Pointer registers and tag storage; reset preloads tags 1..DEPTH-1
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= CAP;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= (i == DEPTH - 1) ? TAG_NONE : TAG_W'(i + 1);
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         if (push0_ok) mem_q[tail_q[IDX_W-1:0]]  <= push_tag_i[0];
         if (push1_ok) mem_q[tail_p1[IDX_W-1:0]] <= push_tag_i[1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/rename_table.sv
// ============================================================================
// Module      : rename_table
// Description : Register alias table for a dual-issue front end. Answers two
//               rename queries combinationally, commits accepted allocations,
//               frees tags on commit and holds one branch checkpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_table
   import rename_table_pkg::*;
#(
   parameter int ARCH_REGS = 32,
   parameter int TAGS      = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [1:0][ARCH_REG_W-1:0]  query_rs1_i,
   input  logic [1:0][ARCH_REG_W-1:0]  query_rs2_i,
   input  logic [1:0][ARCH_REG_W-1:0]  query_rd_i,
   input  logic [1:0]                  query_writes_i,
   output logic [1:0][TAG_W-1:0]       query_rs1_o,
   output logic [1:0][TAG_W-1:0]       query_rs2_o,
   output logic [1:0][TAG_W-1:0]       query_rn_o,
   input  logic                        i_accept,
   input  logic [1:0]                  i_jump,
   input  logic [1:0]                  i_release_valid,
   input  logic [1:0][TAG_W-1:0]       i_release_tag,
   input  logic [1:0][ARCH_REG_W-1:0]  i_release_rd,
   input  logic                        i_mispredict,
   input  logic                        i_branch_ok,
   output logic [PTR_W-1:0]            o_free_count,
   output logic                        o_ckpt_valid,
   output logic                        o_panic
);

   logic [1:0][TAG_W-1:0] head_tag;
   logic [PTR_W-1:0]      fl_head;
   logic                  fl_overflow;

   map_t                  map_q, map_d;
   map_t                  map_rel, ckpt_rel, map_a0, map_a1;
   rename_ckpt_t          ckpt_q, ckpt_d;
   logic                  ckpt_valid_q, ckpt_valid_d;
   logic                  panic_q, panic_d;

   logic [1:0]            wr;
   logic [TAG_W-1:0]      tag1;
   logic                  guard, alloc, restore;
   logic [1:0]            pop_count;

   rename_free_list #(
      .DEPTH (TAGS)
   ) u_free_list (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .pop_count_i    (pop_count),
      .push_valid_i   (i_release_valid),
      .push_tag_i     (i_release_tag),
      .restore_i      (restore),
      .restore_head_i (ckpt_q.head),
      .head_tag_o     (head_tag),
      .head_o         (fl_head),
      .count_o        (o_free_count),
      .overflow_o     (fl_overflow)
   );

   // Source lookups from the committed map; rn is always the free-list view
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         query_rs1_o[k] = (int'(query_rs1_i[k]) < ARCH_REGS) ? map_lookup(map_q, query_rs1_i[k]) : TAG_NONE;
         query_rs2_o[k] = (int'(query_rs2_i[k]) < ARCH_REGS) ? map_lookup(map_q, query_rs2_i[k]) : TAG_NONE;
      end
      query_rn_o   = head_tag;
      o_ckpt_valid = ckpt_valid_q;
      o_panic      = panic_q;
   end

   // Release clears, allocation, checkpoint capture/restore and panic
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         wr[k] = query_writes_i[k] && (query_rd_i[k] != '0);
      end
      // A lone slot-1 writer takes the head tag (pop count of one)
      tag1      = wr[0] ? head_tag[1] : head_tag[0];
      guard     = (wr[0] && (head_tag[0] == TAG_NONE)) || (wr[1] && (tag1 == TAG_NONE));
      alloc     = i_accept && !i_mispredict && !guard;
      pop_count = alloc ? ({1'b0, wr[0]} + {1'b0, wr[1]}) : 2'd0;

      // Clears use the pre-edge map so they never hit a same-cycle allocation
      map_rel  = map_q;
      ckpt_rel = ckpt_q.map;
      for (int k = 0; k < 2; k++) begin
         if (i_release_valid[k]) begin
            if (map_q[i_release_rd[k]] == i_release_tag[k])      map_rel[i_release_rd[k]]  = TAG_NONE;
            if (ckpt_q.map[i_release_rd[k]] == i_release_tag[k]) ckpt_rel[i_release_rd[k]] = TAG_NONE;
         end
      end

      // Slot 1 applied last so it wins on a shared rd
      map_a0 = map_rel;
      if (alloc && wr[0]) map_a0[query_rd_i[0]] = head_tag[0];
      map_a1 = map_a0;
      if (alloc && wr[1]) map_a1[query_rd_i[1]] = tag1;

      map_d        = map_a1;
      restore      = 1'b0;
      ckpt_d       = ckpt_q;
      ckpt_d.map   = ckpt_rel;
      ckpt_valid_d = ckpt_valid_q && !i_branch_ok;

      if (i_mispredict && ckpt_valid_q) begin
         map_d        = ckpt_rel;
         restore      = 1'b1;
         ckpt_valid_d = 1'b0;
      end else if (alloc && (i_jump != 2'b00) && !ckpt_valid_q) begin
         // Snapshot lands right after the jump slot's own rename
         ckpt_valid_d = 1'b1;
         if (i_jump[0]) begin
            ckpt_d.map  = map_a0;
            ckpt_d.head = fl_head + PTR_W'(wr[0]);
         end else begin
            ckpt_d.map  = map_a1;
            ckpt_d.head = fl_head + PTR_W'(pop_count);
         end
      end

      panic_d = panic_q | (i_accept && !i_mispredict && guard) | fl_overflow;
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         map_q        <= '0;
         ckpt_q       <= '0;
         ckpt_valid_q <= 1'b0;
         panic_q      <= 1'b0;
      end else begin
         map_q        <= map_d;
         ckpt_q       <= ckpt_d;
         ckpt_valid_q <= ckpt_valid_d;
         panic_q      <= panic_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rename_table.sv
// ============================================================================
// Module      : tb_rename_table
// Description : Self-checking bench for rename_table: a vector table run
//               through an expected-value queue, then hand-written sequences
//               for reset mid-speculation, exhaustion and release overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rename_table;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0][4:0]  q_rs1, q_rs2, q_rd;
   logic [1:0]       q_wr;
   logic [1:0][5:0]  o_rs1, o_rs2, o_rn;
   logic             acc, mp, bok;
   logic [1:0]       jmp, rv;
   logic [1:0][5:0]  rtag;
   logic [1:0][4:0]  rrd;
   logic [6:0]       cnt;
   logic             ckv, pan;

   int checks   = 0;
   int failures = 0;

   typedef struct { int s0, s1, rd0, w0, rd1, w1, acc, jmp, rv, rt0, rr0, rt1, rr1, mp, bok; } in_t;
   typedef struct { int rs0, rs1, rn0, rn1, cnt, ck, pn; } exp_t;
   typedef struct { in_t i; exp_t e; } vec_t;

   vec_t vecs[16];
   exp_t sb[$];

   rename_table #(.ARCH_REGS(32), .TAGS(64)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .query_rs1_i     (q_rs1),
      .query_rs2_i     (q_rs2),
      .query_rd_i      (q_rd),
      .query_writes_i  (q_wr),
      .query_rs1_o     (o_rs1),
      .query_rs2_o     (o_rs2),
      .query_rn_o      (o_rn),
      .i_accept        (acc),
      .i_jump          (jmp),
      .i_release_valid (rv),
      .i_release_tag   (rtag),
      .i_release_rd    (rrd),
      .i_mispredict    (mp),
      .i_branch_ok     (bok),
      .o_free_count    (cnt),
      .o_ckpt_valid    (ckv),
      .o_panic         (pan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input int expv);
      checks++;
      if (act !== 32'(expv)) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
      end
   endtask

   task automatic drive(input in_t v);
      q_rs1[0] = 5'(v.s0);  q_rs2[0] = 5'd0;
      q_rs1[1] = 5'd0;      q_rs2[1] = 5'(v.s1);
      q_rd[0]  = 5'(v.rd0); q_rd[1]  = 5'(v.rd1);
      q_wr     = {1'(v.w1), 1'(v.w0)};
      acc      = 1'(v.acc);
      jmp      = 2'(v.jmp);
      rv       = 2'(v.rv);
      rtag[0]  = 6'(v.rt0); rrd[0] = 5'(v.rr0);
      rtag[1]  = 6'(v.rt1); rrd[1] = 5'(v.rr1);
      mp       = 1'(v.mp);
      bok      = 1'(v.bok);
   endtask

   task automatic check_outs(input string p, input exp_t e);
      chk({p, "_rs0"}, 32'(o_rs1[0]), e.rs0);
      chk({p, "_rs1"}, 32'(o_rs2[1]), e.rs1);
      chk({p, "_rn0"}, 32'(o_rn[0]),  e.rn0);
      chk({p, "_rn1"}, 32'(o_rn[1]),  e.rn1);
      chk({p, "_cnt"}, 32'(cnt),      e.cnt);
      chk({p, "_ckpt"}, 32'(ckv),     e.ck);
      chk({p, "_panic"}, 32'(pan),    e.pn);
   endtask

   // Drive one cycle's inputs just after the rising edge
   task automatic step(input in_t v);
      @(posedge clk); #1;
      drive(v);
   endtask

   task automatic do_reset();
      in_t z;
      z = '{default: 0};
      @(posedge clk); #1;
      drive(z);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      in_t  z, v;
      exp_t e;
      z   = '{default: 0};
      rst = 1'b1;
      drive(z);

      //            s0 s1 rd0 w0 rd1 w1 acc jmp rv rt0 rr0 rt1 rr1 mp bok    rs0 rs1 rn0 rn1 cnt ck pn
      vecs[0]  = '{'{5, 0, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 1, 2, 63, 0, 0}};
      vecs[1]  = '{'{5, 0, 3, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 1, 2, 63, 0, 0}};
      vecs[2]  = '{'{3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{2, 2, 3, 4, 61, 0, 0}};
      vecs[3]  = '{'{7, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 3, 4, 61, 0, 0}};
      vecs[4]  = '{'{7, 0, 0, 0, 0, 0, 0, 0, 1, 3, 7, 0, 0, 0, 0}, '{3, 0, 4, 5, 60, 0, 0}};
      vecs[5]  = '{'{7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 4, 5, 61, 0, 0}};
      vecs[6]  = '{'{7, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}, '{4, 0, 5, 6, 60, 0, 0}};
      vecs[7]  = '{'{7, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 4, 7, 0, 0}, '{5, 0, 6, 7, 59, 0, 0}};
      vecs[8]  = '{'{7, 3, 3, 1, 0, 0, 1, 0, 1, 2, 3, 0, 0, 0, 0}, '{5, 2, 6, 7, 60, 0, 0}};
      vecs[9]  = '{'{3, 7, 9, 1, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0}, '{6, 5, 7, 8, 60, 0, 0}};
      vecs[10] = '{'{4, 9, 4, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0}, '{8, 7, 9, 10, 58, 1, 0}};
      vecs[11] = '{'{4, 5, 6, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, '{9, 10, 11, 12, 56, 1, 0}};
      vecs[12] = '{'{6, 4, 8, 1, 0, 0, 1, 0, 1, 1, 3, 0, 0, 1, 0}, '{11, 9, 12, 13, 55, 1, 0}};
      vecs[13] = '{'{4, 9, 10, 1, 11, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0}, '{0, 7, 8, 9, 60, 0, 0}};
      vecs[14] = '{'{10, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, '{8, 9, 10, 11, 58, 1, 0}};
      vecs[15] = '{'{10, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{8, 6, 10, 11, 58, 0, 0}};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Table: expected outputs queued with the stimulus, compared at negedge
      for (int i = 0; i < 16; i++) begin
         step(vecs[i].i);
         sb.push_back(vecs[i].e);
         @(negedge clk);
         e = sb.pop_front();
         check_outs($sformatf("v%0d", i), e);
      end

      // Reset while a checkpoint is held
      v = z; v.rd0 = 12; v.w0 = 1; v.acc = 1; v.jmp = 1;
      step(v);
      step(z);
      @(negedge clk);
      chk("spec_ckpt_set", 32'(ckv), 1);
      do_reset();
      @(negedge clk);
      chk("rst_ckpt", 32'(ckv), 0);
      chk("rst_cnt", 32'(cnt), 63);
      chk("rst_rn0", 32'(o_rn[0]), 1);
      chk("rst_rn1", 32'(o_rn[1]), 2);
      chk("rst_panic", 32'(pan), 0);
      v = z; v.s0 = 12;
      drive(v);
      #1 chk("rst_map12", 32'(o_rs1[0]), 0);

      // Exhaustion: 31 pairs leave one free tag (63)
      for (int j = 0; j < 31; j++) begin
         v = z; v.rd0 = 1; v.w0 = 1; v.rd1 = 2; v.w1 = 1; v.acc = 1;
         step(v);
      end
      v = z; v.s0 = 1; v.s1 = 2;
      step(v);
      @(negedge clk);
      chk("exh_cnt", 32'(cnt), 1);
      chk("exh_rn0", 32'(o_rn[0]), 63);
      chk("exh_rn1", 32'(o_rn[1]), 0);
      chk("exh_map1", 32'(o_rs1[0]), 61);
      chk("exh_map2", 32'(o_rs2[1]), 62);
      v = z; v.rd0 = 3; v.w0 = 1; v.rd1 = 4; v.w1 = 1; v.acc = 1;
      step(v);
      v = z; v.s0 = 3;
      step(v);
      @(negedge clk);
      chk("exh_panic", 32'(pan), 1);
      chk("exh_cnt_hold", 32'(cnt), 1);
      chk("exh_no_alloc", 32'(o_rs1[0]), 0);
      v = z; v.rd0 = 5; v.w0 = 1; v.acc = 1;
      step(v);
      v = z; v.s0 = 5;
      step(v);
      @(negedge clk);
      chk("empty_cnt", 32'(cnt), 0);
      chk("empty_rn0", 32'(o_rn[0]), 0);
      chk("empty_rn1", 32'(o_rn[1]), 0);
      chk("empty_map5", 32'(o_rs1[0]), 63);

      // Release overflow into a full list
      do_reset();
      v = z; v.rd0 = 1; v.w0 = 1; v.acc = 1;
      step(v);
      step(z);
      @(negedge clk);
      chk("ovf_cnt62", 32'(cnt), 62);
      v = z; v.rv = 1; v.rt0 = 1; v.rr0 = 1;
      step(v);
      v = z; v.s0 = 1;
      step(v);
      @(negedge clk);
      chk("ovf_cnt63", 32'(cnt), 63);
      chk("ovf_clear", 32'(o_rs1[0]), 0);
      chk("ovf_no_panic", 32'(pan), 0);
      v = z; v.rv = 1; v.rt0 = 1; v.rr0 = 0;
      step(v);
      step(z);
      @(negedge clk);
      chk("ovf_panic", 32'(pan), 1);
      chk("ovf_cnt_hold", 32'(cnt), 63);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rename_table.md
# rename_table

Register alias table and free-tag pool for the dual-issue instruction processor. It sits directly upstream of the Resolver and answers its two `IntfRegQuery` ports combinationally. For each slot it returns the rename tags of the source registers and a fresh destination tag. It records the allocations the Resolver accepts, frees tags on commit, and holds one branch checkpoint so speculative renames can be rolled back on a mispredict.

## Interface
Parameters:
- `ARCH_REGS`, default 32: number of architectural registers; register x0 is never renamed.
- `TAGS`, default 64: size of the tag space. Tag 0 means "no producer / no tag available", so tags 1..63 are allocatable.

Ports:
- `cs.clock`, in, 1: `IntfCSB` clock. There is one clock domain.
- `cs.reset`, in, 1: `IntfCSB` reset. It is synchronous and active-high.
- `query[k].inputs` (k=0,1), in, 5+5+5+1: `rs_1`, `rs_2`, `rd`, `writes` for slot k.
- `query[k].outputs`, out, 6+6+6: `rs_1`, `rs_2`, `rn` tags.
- `i_accept`, in, 1: the Resolver latched both slots this cycle.
- `i_jump`, in, 2: slot k is a jump; it opens a checkpoint on accept.
- `i_release_valid`, in, 2: commit port k frees a tag.
- `i_release_tag`, in, 2×6: the tag being freed.
- `i_release_rd`, in, 2×5: the architectural destination of the freed tag.
- `i_mispredict`, in, 1: restore the checkpoint.
- `i_branch_ok`, in, 1: discard the checkpoint.
- `o_free_count`, out, 7: number of tags currently free.
- `o_ckpt_valid`, out, 1: a checkpoint is held.
- `o_panic`, out, 1: sticky error flag.

## Operation
- **Map table.** `map[0..31]` holds 6-bit entries; 0 means "read the architectural register file". Each `query[k].outputs.rs_n` returns `map[rs_n]`. Register x0 always returns 0.
- **Destination tag.** `rn[0]` is the free-list head and `rn[1]` is head+1, each if available, else 0. `rn[k]` is always driven from the free list, even when slot k does not write.
- **No intra-pair forwarding.** Slot 1's sources do not see slot 0's `rd`; the Resolver handles that case.
- **Allocation.** On `i_accept`, each slot with `writes && rd!=0` pops one tag and sets `map[rd] <= rn[k]`. If both slots write the same `rd`, slot 1 wins. A slot that does not write pops nothing.
- **Allocation guard.**
  - If `i_accept` arrives while a writing slot sees `rn=0`, no state changes and `o_panic` is set. This is a Resolver protocol violation.
  - When slot 0 does not write and slot 1 does, slot 1 pops the head tag. The free list is compacted: a pop count of 1 takes the head.
- **Release.** Each valid release pushes its tag at the tail (port 0 first). If `map[rd]==tag`, the entry clears to 0. The same clear applies to the checkpoint map.
- **Checkpoint.**
  - On `i_accept` with any `i_jump` bit set and no checkpoint held, snapshot the map and head pointer.
  - The snapshot is taken after the jump slot's own allocation but before the following slot's. For a jump in slot 0, slot 1's rename is speculative.
  - A second jump while a checkpoint is held is accepted without a new snapshot. The Resolver never issues this; it is not flagged.
- **Mispredict.** `i_mispredict`: map <= snapshot, head <= snapshot head, checkpoint invalid. Tags allocated after the snapshot return to the pool implicitly.
- **Branch resolved.** `i_branch_ok`: checkpoint invalid, map unchanged.
- **Priority within one cycle:**
  1. reset
  2. mispredict (the `i_accept` allocation is dropped)
  3. accept
- Releases are always applied, including in mispredict cycles.
- On a simultaneous release-clear and allocation to the same `rd`, the allocation wins.

## Timing
- Query outputs are combinational from registered state, with zero latency.
- All updates take effect at the next `cs.clock` rising edge.
- Released tags become allocatable in the following cycle. An allocation sees the pre-release count.
- Reset values:
  - map all 0.
  - free list holds 1..63 in order, head=0, tail=63.
  - `o_free_count`=63.
  - `o_ckpt_valid`=0, `o_panic`=0.
  - `rn[0]`=1, `rn[1]`=2.
- Reset mid-speculation discards the checkpoint.
- Free-list pointers are 7-bit and wrap modulo 64. Count = tail−head.
  - Count 1 → `rn[1]`=0.
  - Count 0 → both 0.
- Releasing into a full list (count 63) sets `o_panic`, and the push is dropped.

## Structure
- `pkg_defines` additions: `ARCH_REG_W=5`, `TAG_W=6`, `TAG_NONE=6'h00`, and a `rename_ckpt_t` struct holding the map array and head pointer.
- Sub-module `rename_free_list`: a 64-entry circular FIFO with 2-pop/2-push. It exposes `head_tag[2]`, `count`, a `restore_head` load, and `overflow`.
- `rename_table` holds the map, the checkpoint, priority logic, and panic.

## Test plan
- **Reset:** after reset, query `rs_1=5, rs_2=0, rd=3, writes=1` on both slots → `rs`=0/0, `rn[0]`=1, `rn[1]`=2, `o_free_count`=63.
- **Same-rd allocation:** accept slot0 `rd=3`, slot1 `rd=3` → next cycle query `rs_1=3` returns 2, count=61.
- **Release:** allocate `x7→1`, then release `(tag=1, rd=7)` → `map[7]`=0, count restored, tag 1 appears at the tail.
- **Release vs re-allocation:** allocate `x7→1`, allocate `x7→2`, release `(1,7)` → `map[7]` stays 2.
- **Mispredict:** jump in slot0 with slot1 writing `x4→2`, then two more pairs. `i_mispredict` → `map[4]` back to 0, head back to 1 (next `rn[0]`=2), `o_ckpt_valid`=0.
- **Exhaustion and panic:** allocate until count=1 → `rn[1]`=0. Accept with both slots writing → `o_panic`=1, count stays 1.
